// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the DDR frame-buffer slot scheduler.
package frame_buf_pkg;

    localparam int SEQ_WIDTH = 8;

    typedef enum logic [1:0] {
        FREE,
        WRITING,
        READY,
        READING
    } slot_state_t;

    // Each line is packed as ceil(res_x / 4) 64-bit words.
    function automatic longint unsigned bytes_per_frame(input longint unsigned res_x,
                                                        input longint unsigned res_y);
        return ((res_x + 64'd3) / 64'd4) * 64'd8 * res_y;
    endfunction

endpackage

// File: rtl/frame_slot_sel.sv
// Combinational slot picker: lowest FREE, oldest READY and newest READY slot.
module frame_slot_sel
    import frame_buf_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  slot_state_t          state [N],
    input  logic [SEQ_WIDTH-1:0] tag   [N],
    output logic                 free_found,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 old_found,
    output logic [IDX_W-1:0]     old_idx,
    output logic                 new_found,
    output logic [IDX_W-1:0]     new_idx
);

    logic signed [SEQ_WIDTH-1:0] old_diff;
    logic signed [SEQ_WIDTH-1:0] new_diff;

    // Tags wrap modulo 256, so age is judged by the signed difference.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        old_found  = 1'b0;
        old_idx    = '0;
        new_found  = 1'b0;
        new_idx    = '0;
        old_diff   = '0;
        new_diff   = '0;
        for (int i = 0; i < N; i++) begin
            if (state[i] == FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (state[i] == READY) begin
                old_diff = tag[i] - tag[old_idx];
                new_diff = tag[i] - tag[new_idx];
                if (!old_found || old_diff < 0) begin
                    old_found = 1'b1;
                    old_idx   = IDX_W'(i);
                end
                if (!new_found || new_diff > 0) begin
                    new_found = 1'b1;
                    new_idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/frame_slot_sched.sv
// Triple-buffer style frame-slot scheduler between the video write and read DMA controllers.
module frame_slot_sched
    import frame_buf_pkg::*;
#(
    parameter int              FRAMES_AMOUNT = 3,
    parameter longint unsigned START_ADDR    = 0,
    parameter int              FRAME_RES_X   = 1920,
    parameter int              FRAME_RES_Y   = 1080,
    parameter int              ADDR_WIDTH    = 32,
    parameter int              CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_req_stb_i,
    input  logic                  wr_done_stb_i,
    input  logic                  wr_abort_stb_i,
    output logic                  wr_grant_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    input  logic                  rd_req_stb_i,
    output logic                  rd_grant_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_valid_o,
    output logic                  rd_new_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output logic [CNT_WIDTH-1:0]  repeat_cnt_o
);

    localparam int IDX_W = (FRAMES_AMOUNT > 1) ? $clog2(FRAMES_AMOUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BPF  = ADDR_WIDTH'(bytes_per_frame(FRAME_RES_X, FRAME_RES_Y));

    function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [IDX_W-1:0] idx);
        return BASE + ADDR_WIDTH'(idx) * BPF;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    slot_state_t          state_q [FRAMES_AMOUNT];
    slot_state_t          s1      [FRAMES_AMOUNT];
    slot_state_t          s2      [FRAMES_AMOUNT];
    slot_state_t          s3      [FRAMES_AMOUNT];
    logic [SEQ_WIDTH-1:0] tag_q   [FRAMES_AMOUNT];
    logic [SEQ_WIDTH-1:0] tag1    [FRAMES_AMOUNT];
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;

    logic             unused_rd_free_found, unused_rd_old_found;
    logic [IDX_W-1:0] unused_rd_free_idx, unused_rd_old_idx;
    logic             unused_wr_new_found;
    logic [IDX_W-1:0] unused_wr_new_idx;
    logic             rd_new_found, wr_free_found, wr_old_found;
    logic [IDX_W-1:0] rd_new_idx, wr_free_idx, wr_old_idx, wr_pick;
    logic             rd_fresh, rd_repeat, reading_found, wr_ok, rd_valid_d;
    logic [IDX_W:0]   drop_inc;

    // Writer completion or abandonment is resolved first.
    always_comb begin
        s1    = state_q;
        tag1  = tag_q;
        seq_d = seq_q;
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (state_q[i] == WRITING) begin
                if (wr_abort_stb_i) begin
                    s1[i] = FREE;
                end else if (wr_done_stb_i) begin
                    s1[i]   = READY;
                    tag1[i] = seq_q;
                    seq_d   = seq_q + 1'b1;
                end
            end
        end
    end

    frame_slot_sel #(.N(FRAMES_AMOUNT), .IDX_W(IDX_W)) u_sel_rd (
        .state      (s1),
        .tag        (tag1),
        .free_found (unused_rd_free_found),
        .free_idx   (unused_rd_free_idx),
        .old_found  (unused_rd_old_found),
        .old_idx    (unused_rd_old_idx),
        .new_found  (rd_new_found),
        .new_idx    (rd_new_idx)
    );

    // Reader takes the newest READY slot; everything older is dropped.
    always_comb begin
        s2            = s1;
        rd_fresh      = 1'b0;
        rd_repeat     = 1'b0;
        reading_found = 1'b0;
        drop_inc      = '0;
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (s1[i] == READING) reading_found = 1'b1;
        end
        if (rd_req_stb_i) begin
            if (rd_new_found) begin
                rd_fresh = 1'b1;
                for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                    if (s1[i] == READING) begin
                        s2[i] = FREE;
                    end else if (s1[i] == READY && IDX_W'(i) != rd_new_idx) begin
                        s2[i]    = FREE;
                        drop_inc = drop_inc + 1'b1;
                    end
                end
                s2[rd_new_idx] = READING;
            end else if (reading_found) begin
                rd_repeat = 1'b1;
            end
        end
        if (wr_req_stb_i) begin
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                if (s2[i] == WRITING) s2[i] = FREE;
            end
        end
    end

    frame_slot_sel #(.N(FRAMES_AMOUNT), .IDX_W(IDX_W)) u_sel_wr (
        .state      (s2),
        .tag        (tag1),
        .free_found (wr_free_found),
        .free_idx   (wr_free_idx),
        .old_found  (wr_old_found),
        .old_idx    (wr_old_idx),
        .new_found  (unused_wr_new_found),
        .new_idx    (unused_wr_new_idx)
    );

    always_comb begin
        s3         = s2;
        wr_pick    = '0;
        wr_ok      = 1'b0;
        rd_valid_d = 1'b0;
        if (wr_req_stb_i) begin
            if (wr_free_found) begin
                wr_pick = wr_free_idx;
                wr_ok   = 1'b1;
            end else if (wr_old_found) begin
                wr_pick = wr_old_idx;
                wr_ok   = 1'b1;
            end
            if (wr_ok) s3[wr_pick] = WRITING;
        end
        for (int i = 0; i < FRAMES_AMOUNT; i++) begin
            if (s3[i] == READING) rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: slot state is a small register array, not a RAM, so it is reset with the rest.
            for (int i = 0; i < FRAMES_AMOUNT; i++) begin
                state_q[i] <= FREE;
                tag_q[i]   <= '0;
            end
            seq_q        <= '0;
            wr_grant_o   <= 1'b0;
            wr_addr_o    <= BASE;
            rd_grant_o   <= 1'b0;
            rd_addr_o    <= BASE;
            rd_valid_o   <= 1'b0;
            rd_new_o     <= 1'b0;
            drop_cnt_o   <= '0;
            repeat_cnt_o <= '0;
        end else begin
            state_q      <= s3;
            tag_q        <= tag1;
            seq_q        <= seq_d;
            wr_grant_o   <= wr_ok;
            if (wr_ok) wr_addr_o <= slot_addr(wr_pick);
            rd_grant_o   <= rd_fresh | rd_repeat;
            rd_new_o     <= rd_fresh;
            if (rd_fresh) rd_addr_o <= slot_addr(rd_new_idx);
            rd_valid_o   <= rd_valid_d;
            drop_cnt_o   <= sat_add(drop_cnt_o, CNT_WIDTH'(drop_inc + (wr_ok && !wr_free_found)));
            repeat_cnt_o <= sat_add(repeat_cnt_o, CNT_WIDTH'(rd_repeat));
        end
    end

endmodule

// File: tb/tb_frame_slot_sched.sv
// Randomized bench for frame_slot_sched against a queue-based slot-ownership model.
module tb_frame_slot_sched;

    localparam int          N       = 3;
    localparam logic [31:0] START   = 32'h0010_0000;
    localparam int          RES_X   = 1922;
    localparam int          RES_Y   = 1080;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          BPF     = ((RES_X + 3) / 4) * 8 * RES_Y;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_req = 1'b0, wr_done = 1'b0, wr_abort = 1'b0, rd_req = 1'b0;
    logic             wr_grant, rd_grant, rd_valid, rd_new;
    logic [31:0]      wr_addr, rd_addr;
    logic [CNT_W-1:0] drop_cnt, repeat_cnt;

    frame_slot_sched #(
        .FRAMES_AMOUNT (N),
        .START_ADDR    (START),
        .FRAME_RES_X   (RES_X),
        .FRAME_RES_Y   (RES_Y),
        .ADDR_WIDTH    (32),
        .CNT_WIDTH     (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wr_req_stb_i   (wr_req),
        .wr_done_stb_i  (wr_done),
        .wr_abort_stb_i (wr_abort),
        .wr_grant_o     (wr_grant),
        .wr_addr_o      (wr_addr),
        .rd_req_stb_i   (rd_req),
        .rd_grant_o     (rd_grant),
        .rd_addr_o      (rd_addr),
        .rd_valid_o     (rd_valid),
        .rd_new_o       (rd_new),
        .drop_cnt_o     (drop_cnt),
        .repeat_cnt_o   (repeat_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: slot ownership as writer slot, reader slot and completed frames in completion order.
    int          writing, reading;
    int          ready_q[$];
    int          drop_m, rep_m;
    bit          exp_wg, exp_rg, exp_rn;
    logic [31:0] exp_wa, exp_ra;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slot_addr(input int i);
        return START + 32'(i * BPF);
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_reset();
        writing = -1;
        reading = -1;
        ready_q.delete();
        drop_m  = 0;
        rep_m   = 0;
        exp_wg  = 0;
        exp_rg  = 0;
        exp_rn  = 0;
        exp_wa  = START;
        exp_ra  = START;
    endtask

    task automatic model_step(input bit wq, input bit wd, input bit wa, input bit rq);
        int  k;
        bit  used;
        exp_wg = 0;
        exp_rg = 0;
        exp_rn = 0;
        if (writing >= 0) begin
            if (wa) begin
                writing = -1;
            end else if (wd) begin
                ready_q.push_back(writing);
                writing = -1;
            end
        end
        if (rq) begin
            if (ready_q.size() > 0) begin
                reading = ready_q[$];
                drop_m  = sat(drop_m + ready_q.size() - 1);
                ready_q.delete();
                exp_rg  = 1;
                exp_rn  = 1;
                exp_ra  = slot_addr(reading);
            end else if (reading >= 0) begin
                rep_m  = sat(rep_m + 1);
                exp_rg = 1;
            end
        end
        if (wq) begin
            writing = -1;
            k = -1;
            for (int i = 0; i < N; i++) begin
                used = (i == reading);
                foreach (ready_q[j]) if (ready_q[j] == i) used = 1;
                if (!used && k < 0) k = i;
            end
            if (k < 0) begin
                k      = ready_q.pop_front();
                drop_m = sat(drop_m + 1);
            end
            writing = k;
            exp_wg  = 1;
            exp_wa  = slot_addr(k);
        end
    endtask

    task automatic compare_all();
        check("wr_grant", wr_grant, exp_wg);
        check("wr_addr", wr_addr, exp_wa);
        check("rd_grant", rd_grant, exp_rg);
        if (exp_rg) check("rd_new", rd_new, exp_rn);
        check("rd_addr", rd_addr, exp_ra);
        check("rd_valid", rd_valid, reading >= 0);
        check("drop_cnt", drop_cnt, drop_m);
        check("repeat_cnt", repeat_cnt, rep_m);
    endtask

    // Called at a falling edge; inputs are sampled at the next rising edge, outputs checked at the following falling edge.
    task automatic step(input bit wq, input bit wd, input bit wa, input bit rq);
        wr_req   = wq;
        wr_done  = wd;
        wr_abort = wa;
        rd_req   = rq;
        model_step(wq, wd, wa, rq);
        @(negedge clk);
        wr_req   = 0;
        wr_done  = 0;
        wr_abort = 0;
        rd_req   = 0;
        compare_all();
    endtask

    task automatic apply_reset();
        #2 rst_n = 0;
        #1;
        check("rst_wr_grant", wr_grant, 0);
        check("rst_rd_grant", rd_grant, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_new", rd_new, 0);
        check("rst_wr_addr", wr_addr, START);
        check("rst_rd_addr", rd_addr, START);
        check("rst_drop", drop_cnt, 0);
        check("rst_repeat", repeat_cnt, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // First frame
        step(1, 0, 0, 0);
        check("first_wr_addr", wr_addr, START);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check("first_rd_new", rd_new, 1);
        check("first_rd_addr", rd_addr, START);

        // Repeat
        step(0, 0, 0, 1);
        check("repeat_new", rd_new, 0);
        check("repeat_cnt1", repeat_cnt, 1);

        // Overrun: slots 1 and 2 complete while reader holds slot 0
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("overrun_addr", wr_addr, slot_addr(1));
        check("overrun_drop", drop_cnt, 1);

        // Same-cycle done and read request
        step(0, 1, 0, 1);
        check("same_cycle_new", rd_new, 1);
        check("same_cycle_addr", rd_addr, slot_addr(1));

        // Abort beats done
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        check("abort_rd_new", rd_new, 0);

        // Reset mid-frame
        step(1, 0, 0, 0);
        apply_reset();
        step(1, 0, 0, 0);
        check("post_reset_addr", wr_addr, START);

        // Randomized traffic, including strobes with no writer active and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_slot_sched.md
# frame_slot_sched

Frame-slot scheduler for the DDR frame buffer. It owns the FRAMES_AMOUNT frame slots that sit between the video write DMA controller and the video read DMA controller, and hands each side a slot base address at its frame boundaries. Allocation is triple-buffer style: the writer never overwrites the frame being read, and the reader always gets the newest complete frame. Dropped and repeated frames are counted for software status.

## Interface
- FRAMES_AMOUNT, 3: number of slots; must be ≥ 2.
- START_ADDR, 0: byte address of slot 0.
- FRAME_RES_X, 1920: pixels per line.
- FRAME_RES_Y, 1080: lines per frame.
- ADDR_WIDTH, 32: address width.
- CNT_WIDTH, 16: width of the status counters.

Ports:
- clk_i  in  1  single clock for the block.
- rst_n_i  in  1  asynchronous, active-low reset.
- wr_req_stb_i  in  1  writer is starting a frame and requests a slot.
- wr_done_stb_i  in  1  writer completed its current frame.
- wr_abort_stb_i  in  1  writer abandoned its current frame.
- wr_grant_o  out  1  one-cycle pulse: writer slot assigned.
- wr_addr_o  out  ADDR_WIDTH  base address of the writer slot.
- rd_req_stb_i  in  1  reader is at a frame boundary and requests the next frame.
- rd_grant_o  out  1  one-cycle pulse: reader slot (re)assigned.
- rd_addr_o  out  ADDR_WIDTH  base address of the reader slot.
- rd_valid_o  out  1  reader holds a slot.
- rd_new_o  out  1  qualifies rd_grant_o: 1 = fresh frame, 0 = repeat.
- drop_cnt_o  out  CNT_WIDTH  frames overwritten before they were read; saturating.
- repeat_cnt_o  out  CNT_WIDTH  reader grants with no fresh frame; saturating.

## Operation
- Each slot is in one of four states: FREE, WRITING, READY, READING. Each slot also stores an 8-bit sequence tag.
- Slot address = START_ADDR + slot × BYTES_PER_FRAME.
  - WORDS_PER_LINE = ceil(FRAME_RES_X / 4).
  - BYTES_PER_FRAME = WORDS_PER_LINE × 8 × FRAME_RES_Y.
- Events that arrive in the same cycle are applied in a fixed order. Each step sees the result of the step before it:
  1. **wr_done / wr_abort.**
     - wr_done: WRITING→READY, and the slot is tagged with seq_cnt; seq_cnt increments modulo 256.
     - wr_abort: WRITING→FREE.
     - If both strobes are asserted, abort wins.
     - Either strobe with no WRITING slot is ignored.
  2. **rd_req.**
     - If any slot is READY, select the newest READY slot. Newest means the largest tag, compared as the signed 8-bit difference.
     - That slot goes READY→READING. The previous READING slot, if any, goes to FREE.
     - Response: rd_new_o=1, rd_valid_o=1.
     - Else if a READING slot exists, it is kept and repeat_cnt increments. Response: rd_new_o=0.
     - Else there is no grant and rd_valid_o stays 0.
  3. **wr_req.**
     - Any WRITING slot is first returned to FREE (an implicit abort).
     - The lowest-index FREE slot is chosen.
     - If there is no FREE slot, the oldest READY slot is chosen and drop_cnt increments.
     - The chosen slot goes →WRITING and wr_grant_o fires.
- Any older READY slot left behind when the reader takes a newer one is returned to FREE and counted in drop_cnt.
- A READING slot is never chosen for the writer. With FRAMES_AMOUNT ≥ 2, a wr_req always finds a slot.
- Counters saturate at all-ones.

## Timing
- All outputs are registered. Each grant, address and flag appears in the cycle after the request strobe.
- Back-to-back requests on consecutive cycles are legal and each one is served.
- Reset values:
  - All slots FREE; seq_cnt 0.
  - wr_grant_o 0, rd_grant_o 0, rd_valid_o 0, rd_new_o 0.
  - wr_addr_o and rd_addr_o = START_ADDR.
  - Both counters 0.
- Reset asserted in the middle of a frame discards all slot state immediately. The DMA controllers are reset by the same signal.
- wr_addr_o and rd_addr_o hold their value between grants.

## Structure
- frame_buf_pkg holds:
  - the slot_state_t enum (FREE, WRITING, READY, READING);
  - the function computing BYTES_PER_FRAME from FRAME_RES_X and FRAME_RES_Y;
  - the SEQ_WIDTH = 8 constant.
- Sub-module frame_slot_sel: purely combinational. It takes the state and tag arrays and returns the lowest FREE, oldest READY and newest READY indices, each with a found flag. It is instantiated once per evaluation step.

## Test plan
- **First frame.** After reset: wr_req, then wr_done, then rd_req. Expect a wr_grant with addr START_ADDR (slot 0), then a rd_grant with rd_new=1 and the same address.
- **Repeat.** Reader holds slot 0 and no new frame is ready; rd_req. Expect rd_grant with rd_new=0, unchanged address, repeat_cnt=1.
- **Overrun (FRAMES_AMOUNT=3).** Reader holds slot 0; the writer completes frames into slots 1 and 2; then wr_req. Expect slot 1 (oldest READY) granted and drop_cnt=1.
- **Same-cycle events.** wr_done and rd_req in the same cycle. Expect the reader to receive the just-completed slot with rd_new=1.
- **Abort precedence.** wr_abort and wr_done together, then rd_req. Expect no READY slot, rd_new=0 (or no grant if the reader holds nothing), and the slot returned to FREE.
- **Reset mid-frame.** Assert rst_n_i low while a slot is WRITING or READING. Expect all outputs at their reset values, and the next wr_req granted slot 0.
